dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (MemoriadeDatos) used by the memory stage.
- Port A is the CPU memory stage; port B is the secondary reader/writer (display/debug/UART loader).
- Serializes accesses with a req/ack handshake and round-robin (or fixed) priority.
- Registers the memory control signals and returns read data with a one-cycle ack pulse.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and sequencer in front of a single-port data memory.
//   Port A is the CPU memory stage and port B is the secondary requester
//   (display/debug/UART loader). Each request is served as
//   IDLE -> ACCESS -> RESP, so one transaction completes every three cycles.
//   The memory control outputs are registered. Read data is returned on a
//   one-cycle ack pulse and is held until the next read on that port.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   a_req/a_we/a_addr/a_wdata        port A request, fields stable until a_ack
//   a_ack, a_rdata                   port A completion pulse and read data
//   b_req/b_we/b_addr/b_wdata        port B request, fields stable until b_ack
//   b_ack, b_rdata                   port B completion pulse and read data
//   mem_we, mem_addr, mem_wdata      memory write enable, address, write data
//   mem_rdata                        memory read data (combinational from mem_addr)
//   busy                             high while in ACCESS or RESP
//
// Parameters
//   AW, DW       address and data widths, passed through unmodified
//   FIXED_PRIO   0 = round-robin on ties, 1 = port A always wins ties
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   cur;         // port being served: 0 = A, 1 = B
  logic   last_grant;  // most recent winner: 0 = A, 1 = B
  logic   pick_b;

  // B wins when it is the only requester, or on a tie under round-robin
  // when A was the most recent winner.
  always_comb begin
    pick_b = 1'b0;
    if (b_req) begin
      if (!a_req)
        pick_b = 1'b1;
      else if ((FIXED_PRIO == 0) && (last_grant == 1'b0))
        pick_b = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= 1'b0;
      last_grant <= 1'b1;  // A takes the first tie after reset
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          mem_we <= 1'b0;
          if (a_req || b_req) begin
            cur        <= pick_b;
            last_grant <= pick_b;
            mem_we     <= pick_b ? b_we    : a_we;
            mem_addr   <= pick_b ? b_addr  : a_addr;
            mem_wdata  <= pick_b ? b_wdata : a_wdata;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          // mem_we still holds the latched direction during this cycle;
          // read data is only captured for reads.
          if (!mem_we) begin
            if (cur)
              b_rdata <= mem_rdata;
            else
              a_rdata <= mem_rdata;
          end
          mem_we <= 1'b0;
          a_ack  <= ~cur;
          b_ack  <= cur;
          state  <= RESP;
        end

        RESP: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem_we <= 1'b0;
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a round-robin instance backed by a small
// memory model, plus a fixed-priority instance backed by an address-derived
// read pattern. Expected responses are queued when a request is driven and
// popped when an ack appears.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;

  // round-robin instance
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // fixed-priority instance
  logic        f_a_req, f_a_we, f_a_ack, f_b_req, f_b_we, f_b_ack;
  logic [31:0] f_a_addr, f_a_wdata, f_a_rdata, f_b_addr, f_b_wdata, f_b_rdata;
  logic        f_mem_we, f_busy;
  logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;

  dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(f_a_req), .a_we(f_a_we), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_ack(f_b_ack), .b_rdata(f_b_rdata),
    .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  // memory model: 256 words, combinational read, write at rising edge
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // fixed-priority instance reads a pattern derived from the address
  assign f_mem_rdata = f_mem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total;
  int   bad;
  int   overlap;

  task automatic step();
    @(posedge clk);
    #1;
    if (a_ack && b_ack) overlap++;
    if (f_a_ack && f_b_ack) overlap++;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    f_a_req = 0; f_a_we = 0; f_a_addr = '0; f_a_wdata = '0;
    f_b_req = 0; f_b_we = 0; f_b_addr = '0; f_b_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  // steps until an ack appears on the chosen instance or budget runs out
  task automatic wait_ack(input bit fp, input int budget, output bit got,
                          output bit port, output int n, output logic [31:0] rd);
    got = 0; port = 0; n = 0; rd = '0;
    while (!got && n < budget) begin
      step();
      n++;
      if (fp) begin
        if (f_a_ack)      begin got = 1; port = 0; rd = f_a_rdata; end
        else if (f_b_ack) begin got = 1; port = 1; rd = f_b_rdata; end
      end else begin
        if (a_ack)        begin got = 1; port = 0; rd = a_rdata; end
        else if (b_ack)   begin got = 1; port = 1; rd = b_rdata; end
      end
    end
  endtask

  task automatic do_write(input bit port, input logic [31:0] addr, input logic [31:0] data);
    bit g, p; int n; logic [31:0] r;
    if (port) begin b_req = 1; b_we = 1; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_we = 1; a_addr = addr; a_wdata = data; end
    wait_ack(0, 8, g, p, n, r);
    a_req = 0; a_we = 0; b_req = 0; b_we = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step();
    total++;
    if ({mem_we, mem_addr, mem_wdata, a_ack, b_ack, a_rdata, b_rdata, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: mem_we=%0b addr=%h wdata=%h acks=%0b%0b rdata=%h/%h busy=%0b, want all zero",
               mem_we, mem_addr, mem_wdata, a_ack, b_ack, a_rdata, b_rdata, busy);
    end
    rst_n = 1;
    step();
    total++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%0b mem_we=%0b, want 0 0", busy, mem_we);
    end
  endtask

  task automatic test_single_write();
    bit g, p; int n; logic [31:0] r;
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
    sbq.push_back('{port: 1'b0, rdata: 32'h0});  // write leaves a_rdata at reset value
    step();
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_access: we=%0b addr=%h wdata=%h busy=%0b, want 1 00000010 deadbeef 1",
               mem_we, mem_addr, mem_wdata, busy);
    end
    wait_ack(0, 6, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata || n != 1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL write_ack: got=%0b port=%0b rdata=%h lat=%0d mem_we=%0b, want 1 %0b %h 1 0",
               g, p, r, n, mem_we, e.port, e.rdata);
    end
    a_req = 0; a_we = 0;
    step();
    total++;
    if (a_ack !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_ack_pulse: a_ack=%0b busy=%0b, want 0 0", a_ack, busy);
    end
    a_req = 1;
    sbq.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
    wait_ack(0, 6, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata || n != 2) begin
      bad++;
      $display("FAIL read_back: got=%0b port=%0b rdata=%h lat=%0d, want 1 %0b %h 2",
               g, p, r, n, e.port, e.rdata);
    end
    a_req = 0;
    step();
  endtask

  task automatic test_simul_reads();
    bit g, p; int n; logic [31:0] r;
    apply_reset();
    do_write(0, 32'h4, 32'hAAAA0004);
    do_write(1, 32'h8, 32'hBBBB0008);
    apply_reset();
    overlap = 0;
    a_req = 1; a_addr = 32'h4;
    b_req = 1; b_addr = 32'h8;
    sbq.push_back('{port: 1'b0, rdata: 32'hAAAA0004});
    sbq.push_back('{port: 1'b1, rdata: 32'hBBBB0008});
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata || n != 2) begin
      bad++;
      $display("FAIL simul_first: got=%0b port=%0b rdata=%h lat=%0d, want 1 %0b %h 2",
               g, p, r, n, e.port, e.rdata);
    end
    a_req = 0;
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata || n != 3) begin
      bad++;
      $display("FAIL simul_second: got=%0b port=%0b rdata=%h lat=%0d, want 1 %0b %h 3",
               g, p, r, n, e.port, e.rdata);
    end
    b_req = 0;
    step();
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL ack_overlap: overlapping cycles=%0d, want 0", overlap);
    end
  endtask

  task automatic test_round_robin();
    bit g, p; int n; logic [31:0] r;
    apply_reset();
    overlap = 0;
    a_req = 1; a_addr = 32'h4;
    b_req = 1; b_addr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sbq.push_back('{port: 1'b0, rdata: 32'hAAAA0004});
      else            sbq.push_back('{port: 1'b1, rdata: 32'hBBBB0008});
    end
    for (int i = 0; i < 6; i++) begin
      wait_ack(0, 8, g, p, n, r);
      e = sbq.pop_front();
      total++;
      if (!g || p !== e.port || r !== e.rdata || n != ((i == 0) ? 2 : 3)) begin
        bad++;
        $display("FAIL rr_grant%0d: got=%0b port=%0b rdata=%h gap=%0d, want 1 %0b %h %0d",
                 i, g, p, r, n, e.port, e.rdata, (i == 0) ? 2 : 3);
      end
    end
    a_req = 0; b_req = 0;
    step();
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL rr_overlap: overlapping cycles=%0d, want 0", overlap);
    end
  endtask

  task automatic test_fixed_prio();
    bit g, p; int n; logic [31:0] r;
    apply_reset();
    f_a_req = 1; f_a_addr = 32'h100;
    f_b_req = 1; f_b_addr = 32'h200;
    for (int i = 0; i < 4; i++) sbq.push_back('{port: 1'b0, rdata: 32'h100 ^ 32'hA5A5_0000});
    sbq.push_back('{port: 1'b1, rdata: 32'h200 ^ 32'hA5A5_0000});
    for (int i = 0; i < 4; i++) begin
      wait_ack(1, 8, g, p, n, r);
      e = sbq.pop_front();
      total++;
      if (!g || p !== e.port || r !== e.rdata) begin
        bad++;
        $display("FAIL fp_a_wins%0d: got=%0b port=%0b rdata=%h, want 1 %0b %h",
                 i, g, p, r, e.port, e.rdata);
      end
    end
    f_a_req = 0;
    wait_ack(1, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata || n != 3) begin
      bad++;
      $display("FAIL fp_b_after_a: got=%0b port=%0b rdata=%h lat=%0d, want 1 %0b %h 3",
               g, p, r, n, e.port, e.rdata);
    end
    f_b_req = 0;
    step();
  endtask

  task automatic test_reset_mid_write();
    bit g, p; int n; logic [31:0] r;
    apply_reset();
    do_write(1, 32'h20, 32'h11111111);
    b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h55;
    step();
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20) begin
      bad++;
      $display("FAIL midrst_access: we=%0b addr=%h, want 1 00000020", mem_we, mem_addr);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_we_drop: we=%0b busy=%0b, want 0 0", mem_we, busy);
    end
    b_req = 0; b_we = 0;
    step();
    total++;
    if (b_ack !== 1'b0 || mem[8] !== 32'h11111111) begin
      bad++;
      $display("FAIL midrst_no_commit: b_ack=%0b mem=%h, want 0 11111111", b_ack, mem[8]);
    end
    rst_n = 1;
    step();
    total++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || b_ack !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle: busy=%0b we=%0b b_ack=%0b, want 0 0 0", busy, mem_we, b_ack);
    end
    // both request after reset: A must win the first tie
    a_req = 1; a_addr = 32'h20;
    b_req = 1; b_addr = 32'h4;
    sbq.push_back('{port: 1'b0, rdata: 32'h11111111});
    sbq.push_back('{port: 1'b1, rdata: 32'hAAAA0004});
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata) begin
      bad++;
      $display("FAIL midrst_readback: got=%0b port=%0b rdata=%h, want 1 %0b %h",
               g, p, r, e.port, e.rdata);
    end
    a_req = 0;
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata) begin
      bad++;
      $display("FAIL midrst_b_read: got=%0b port=%0b rdata=%h, want 1 %0b %h",
               g, p, r, e.port, e.rdata);
    end
    b_req = 0;
    step();
  endtask

  task automatic test_isolation();
    bit g, p; int n; logic [31:0] r;
    do_write(0, 32'h40, 32'h9999);
    do_write(1, 32'h30, 32'h1234);
    a_req = 1; a_addr = 32'h40;
    sbq.push_back('{port: 1'b0, rdata: 32'h9999});
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata) begin
      bad++;
      $display("FAIL iso_a_read: got=%0b port=%0b rdata=%h, want 1 %0b %h",
               g, p, r, e.port, e.rdata);
    end
    a_req = 0;
    step();
    b_req = 1; b_addr = 32'h30;
    sbq.push_back('{port: 1'b1, rdata: 32'h1234});
    wait_ack(0, 8, g, p, n, r);
    e = sbq.pop_front();
    total++;
    if (!g || p !== e.port || r !== e.rdata) begin
      bad++;
      $display("FAIL iso_b_read: got=%0b port=%0b rdata=%h, want 1 %0b %h",
               g, p, r, e.port, e.rdata);
    end
    total++;
    if (a_rdata !== 32'h9999) begin
      bad++;
      $display("FAIL iso_a_held: a_rdata=%h, want 00009999", a_rdata);
    end
    b_req = 0;
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    overlap = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_simul_reads();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_write();
    test_isolation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
